// File: rtl/sevenseg_reader.sv
// Multiplexed seven-segment bus receiver: synchronizes the segment and digit-select
// lines, captures each stable digit glyph, decodes it and publishes whole frames.
module sevenseg_reader #(
   parameter int NDIGITS       = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [6:0]             seg,
   input  logic [NDIGITS-1:0]     dig_sel,
   output logic [4*NDIGITS-1:0]   value,
   output logic                   valid,
   output logic [NDIGITS-1:0]     err
);

   localparam int         SW     = NDIGITS + 7;
   localparam logic [7:0] THRESH = 8'(STABLE_CYCLES - 1);

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_PUBLISH = 1'b1;

   // Returns {illegal, nibble}; unknown glyphs decode to nibble 0 with the flag set.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         7'h77:   r = 5'h0A;
         7'h7C:   r = 5'h0B;
         7'h39:   r = 5'h0C;
         7'h5E:   r = 5'h0D;
         7'h79:   r = 5'h0E;
         7'h71:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   logic [6:0]           seg_m_q, seg_m_d, seg_s_q, seg_s_d;
   logic [NDIGITS-1:0]   sel_m_q, sel_m_d, sel_s_q, sel_s_d;
   logic [SW-1:0]        prev_q, prev_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic [NDIGITS-1:0]   seen_q, seen_d;
   logic [4*NDIGITS-1:0] nib_q, nib_d;
   logic [NDIGITS-1:0]   ebuf_q, ebuf_d;
   logic [0:0]           state_q, state_d;
   logic [4*NDIGITS-1:0] value_q, value_d;
   logic [NDIGITS-1:0]   err_q, err_d;

   logic [6:0]           seg_cur;
   logic [SW-1:0]        cur;
   logic                 same;
   logic                 onehot;
   logic [4:0]           dec;
   logic                 capture;

   assign seg_cur = (ACTIVE_LOW != 0) ? ~seg_s_q : seg_s_q;
   assign cur     = {sel_s_q, seg_cur};
   assign same    = (cur == prev_q);
   assign onehot  = (sel_s_q != '0) && ((sel_s_q & (sel_s_q - NDIGITS'(1))) == '0);
   assign dec     = decode_glyph(seg_cur);

   // A pattern change in the same cycle the count matures must not capture, hence 'same'.
   assign capture = same && (cnt_q == THRESH) && !done_q && onehot &&
                    (state_q == ST_COLLECT);

   always_comb begin
      seg_m_d = seg;
      seg_s_d = seg_m_q;
      sel_m_d = dig_sel;
      sel_s_d = sel_m_q;
      prev_d  = cur;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (!same) begin
         cnt_d  = 8'd0;
         done_d = 1'b0;
      end else begin
         if (cnt_q != THRESH) begin
            cnt_d = cnt_q + 8'd1;
         end
         if (capture) begin
            done_d = 1'b1;
         end
      end
   end

   always_comb begin
      nib_d  = nib_q;
      ebuf_d = ebuf_q;
      seen_d = seen_q;
      if (capture) begin
         for (int k = 0; k < NDIGITS; k++) begin
            if (sel_s_q[k]) begin
               nib_d[4*k +: 4] = dec[3:0];
               ebuf_d[k]       = dec[4];
               seen_d[k]       = 1'b1;
            end
         end
      end

      state_d = state_q;
      value_d = value_q;
      err_d   = err_q;
      case (state_q)
         ST_COLLECT: begin
            // Publish registers follow the buffers as they stand after this capture.
            if (seen_d == '1) begin
               state_d = ST_PUBLISH;
               value_d = nib_d;
               err_d   = ebuf_d;
            end
         end
         default: begin
            seen_d  = '0;
            state_d = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m_q <= '0;
         seg_s_q <= '0;
         sel_m_q <= '0;
         sel_s_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         seen_q  <= '0;
         nib_q   <= '0;
         ebuf_q  <= '0;
         state_q <= ST_COLLECT;
         value_q <= '0;
         err_q   <= '0;
      end else begin
         seg_m_q <= seg_m_d;
         seg_s_q <= seg_s_d;
         sel_m_q <= sel_m_d;
         sel_s_q <= sel_s_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         seen_q  <= seen_d;
         nib_q   <= nib_d;
         ebuf_q  <= ebuf_d;
         state_q <= state_d;
         value_q <= value_d;
         err_q   <= err_d;
      end
   end

   assign value = value_q;
   assign err   = err_q;
   assign valid = (state_q == ST_PUBLISH);

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader: an active-high and an active-low instance see the same bus,
// directed scenarios plus a randomized dwell sequence checked against a frame model.
module tb_sevenseg_reader;

   localparam int ND = 4;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel;
   logic [15:0] value0, value1;
   logic        valid0, valid1;
   logic [3:0]  err0, err1;

   always #5 clk = ~clk;
   assign seg_n = ~seg;

   sevenseg_reader #(.NDIGITS(ND), .STABLE_CYCLES(SC), .ACTIVE_LOW(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
      .value(value0), .valid(valid0), .err(err0));

   sevenseg_reader #(.NDIGITS(ND), .STABLE_CYCLES(SC), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .seg(seg_n), .dig_sel(dig_sel),
      .value(value1), .valid(valid1), .err(err1));

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [19:0] pub0[$];
   logic [19:0] pub1[$];

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   always @(negedge clk) begin
      if (valid0) pub0.push_back({err0, value0});
      if (valid1) pub1.push_back({err1, value1});
   end

   function automatic int npub(int d);
      return (d != 0) ? pub1.size() : pub0.size();
   endfunction

   function automatic logic [19:0] pub(int d, int i);
      if (d != 0) return (i < pub1.size()) ? pub1[i] : 20'hxxxxx;
      return (i < pub0.size()) ? pub0[i] : 20'hxxxxx;
   endfunction

   function automatic logic [20:0] outs(int d);
      return (d != 0) ? {err1, value1, valid1} : {err0, value0, valid0};
   endfunction

   function automatic logic [4:0] ref_decode(logic [6:0] s);
      for (int n = 0; n < 16; n++) begin
         if (glyph[n] == s) return {1'b0, 4'(n)};
      end
      return 5'h10;
   endfunction

   task automatic hold(input logic [3:0] sel, input logic [6:0] s, input int len);
      dig_sel = sel;
      seg     = s;
      repeat (len) @(negedge clk);
   endtask

   task automatic do_reset;
      dig_sel = 4'h0;
      seg     = 7'h00;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      pub0.delete();
      pub1.delete();
   endtask

   task automatic test_reset;
      dig_sel = 4'h0;
      seg     = 7'h00;
      rst_n   = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (outs(d) !== 21'h0)
            $display("FAIL reset_state dut%0d: got {err,value,valid}=%h, want 0", d, outs(d));
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (outs(d) !== 21'h0)
            $display("FAIL reset_idle dut%0d: got %h, want 0", d, outs(d));
         else pass_cnt++;
      end
   endtask

   task automatic test_clean_frame;
      do_reset();
      hold(4'b0001, 7'h06, 8);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h4F, 8);
      dig_sel = 4'b1000;
      seg     = 7'h66;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (outs(d)[0] !== (i == 7))
               $display("FAIL clean_latency dut%0d cycle %0d: valid=%b, want %b",
                        d, i, outs(d)[0], (i == 7));
            else pass_cnt++;
         end
      end
      @(negedge clk);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h04321)
            $display("FAIL clean_frame dut%0d: got %0d pulses first=%h, want 1 pulse 04321",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_glitch;
      do_reset();
      hold(4'b0001, 7'h3F, 3);
      hold(4'b0001, 7'h06, 8);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h4F, 8);
      hold(4'b1000, 7'h66, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h04321)
            $display("FAIL glitch dut%0d: got %0d pulses first=%h, want 1 pulse 04321",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_illegal;
      do_reset();
      hold(4'b0001, 7'h06, 8);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h00, 8);
      hold(4'b1000, 7'h66, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h44021)
            $display("FAIL illegal dut%0d: got %0d pulses first=%h, want 1 pulse 44021",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_bus_faults;
      do_reset();
      hold(4'b0011, 7'h3F, 10);
      hold(4'b0000, 7'h3F, 10);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h4F, 8);
      hold(4'b1000, 7'h66, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 0)
            $display("FAIL bus_fault_capture dut%0d: got %0d pulses, want 0", d, npub(d));
         else pass_cnt++;
      end
      hold(4'b0001, 7'h06, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h04321)
            $display("FAIL bus_fault_frame dut%0d: got %0d pulses first=%h, want 1 pulse 04321",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_active_low_reset;
      do_reset();
      for (int k = 0; k < 4; k++) hold(4'(1 << k), 7'h7F, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h08888)
            $display("FAIL eights dut%0d: got %0d pulses first=%h, want 1 pulse 08888",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
      hold(4'b0001, 7'h06, 8);
      hold(4'b0010, 7'h5B, 8);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (outs(d) !== 21'h0)
            $display("FAIL midframe_reset dut%0d: got {err,value,valid}=%h, want 0", d, outs(d));
         else pass_cnt++;
      end
      dig_sel = 4'h0;
      seg     = 7'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      pub0.delete();
      pub1.delete();
      hold(4'b0100, 7'h4F, 8);
      hold(4'b1000, 7'h66, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 0)
            $display("FAIL reset_mask dut%0d: got %0d pulses, want 0", d, npub(d));
         else pass_cnt++;
      end
      hold(4'b0001, 7'h7D, 8);
      hold(4'b0010, 7'h07, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h04376)
            $display("FAIL post_reset_frame dut%0d: got %0d pulses first=%h, want 1 pulse 04376",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_overwrite;
      do_reset();
      hold(4'b0001, 7'h06, 8);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h4F, 8);
      hold(4'b0010, 7'h07, 8);
      hold(4'b1000, 7'h66, 8);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 1 || pub(d, 0) !== 20'h04371)
            $display("FAIL overwrite dut%0d: got %0d pulses first=%h, want 1 pulse 04371",
                     d, npub(d), pub(d, 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      hold(4'b0001, 7'h06, SC + 1);
      hold(4'b0010, 7'h5B, SC + 1);
      hold(4'b0100, 7'h4F, SC + 1);
      hold(4'b1000, 7'h66, SC + 1);
      hold(4'b0001, 7'h7D, SC + 1);
      hold(4'b0010, 7'h07, SC + 1);
      hold(4'b0001, 7'h3F, SC);
      hold(4'b0100, 7'h7F, SC + 1);
      hold(4'b1000, 7'h6F, SC + 1);
      hold(4'b0000, 7'h00, 10);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== 2 || pub(d, 0) !== 20'h04321 || pub(d, 1) !== 20'h09876)
            $display("FAIL back_to_back dut%0d: got %0d pulses %h %h, want 2 pulses 04321 09876",
                     d, npub(d), pub(d, 0), pub(d, 1));
         else pass_cnt++;
      end
   endtask

   task automatic test_random;
      logic [3:0]  m_nib [4];
      logic [3:0]  m_err;
      logic [3:0]  m_seen;
      logic [19:0] exp_q[$];
      logic [3:0]  sel, psel;
      logic [6:0]  s, pseg;
      logic [4:0]  d5;
      int          r, len;
      do_reset();
      m_seen = 4'h0;
      m_err  = 4'h0;
      for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
      psel = 4'h0;
      pseg = 7'h00;
      for (int n = 0; n < 250; n++) begin
         do begin
            r = $urandom_range(0, 99);
            if (r < 70)      sel = 4'b0001 << $urandom_range(0, 3);
            else if (r < 85) sel = 4'h0;
            else             sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 80) s = glyph[$urandom_range(0, 15)];
            else                            s = 7'($urandom_range(0, 127));
         end while (sel == psel && s == pseg);
         if ($urandom_range(0, 1) != 0) len = $urandom_range(SC + 1, SC + 5);
         else                           len = $urandom_range(1, SC);
         hold(sel, s, len);
         psel = sel;
         pseg = s;
         // A one-hot pattern held longer than STABLE_CYCLES yields exactly one capture.
         if ($countones(sel) == 1 && len > SC) begin
            d5 = ref_decode(s);
            for (int k = 0; k < 4; k++) begin
               if (sel[k]) begin
                  m_nib[k]  = d5[3:0];
                  m_err[k]  = d5[4];
                  m_seen[k] = 1'b1;
               end
            end
            if (m_seen == 4'hF) begin
               exp_q.push_back({m_err, m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
               m_seen = 4'h0;
            end
         end
      end
      hold(4'b0000, 7'h00, 12);
      for (int d = 0; d < 2; d++) begin
         chk_cnt++;
         if (npub(d) !== exp_q.size())
            $display("FAIL random_count dut%0d: got %0d frames, want %0d", d, npub(d), exp_q.size());
         else pass_cnt++;
         for (int i = 0; i < exp_q.size(); i++) begin
            chk_cnt++;
            if (pub(d, i) !== exp_q[i])
               $display("FAIL random_frame dut%0d #%0d: got %h, want %h", d, i, pub(d, i), exp_q[i]);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_illegal();
      test_bus_faults();
      test_active_low_reset();
      test_overwrite();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
